button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 179 +++++++++++++++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Five-channel push-button conditioner. Each raw button passes
//               through a two-flop synchronizer and polarity correction, then
//               a per-channel debounce FSM. Accepted presses yield a
//               debounced level plus a one-cycle strobe. Selected channels
//               also auto-repeat the strobe while held.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               btn_raw    - asynchronous raw buttons
//                            (0 Set_Clock, 1 MIN, 2 HR, 3 Set_Alarm, 4 Alarm_Off)
//               btn_level  - debounced pressed level, active-high
//               btn_pulse  - single-cycle press / auto-repeat strobe
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         REPEAT_DELAY    = 2500000,
    parameter int         REPEAT_PERIOD   = 1000000,
    parameter logic [4:0] REPEAT_MASK     = 5'b00110,
    parameter logic       ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int c_num_ch  = 5;
    localparam int c_max_ab  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_max_cnt = (c_max_ab > REPEAT_PERIOD) ? c_max_ab : REPEAT_PERIOD;
    // Counters only ever need to hold (parameter - 1).
    localparam int c_cnt_w   = (c_max_cnt < 2) ? 1 : $clog2(c_max_cnt);

    localparam logic [c_cnt_w-1:0] c_db_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rd_last  = c_cnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_rp_last  = c_cnt_w'(REPEAT_PERIOD - 1);
    localparam logic [4:0]         c_released = {c_num_ch{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_RELEASED    = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_PRESSED     = 2'd2,
        S_RELEASE_CHK = 2'd3
    } state_t;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_pressed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= c_released;
            r_sync2 <= c_released;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
        localparam logic c_rep_en = REPEAT_MASK[gi];

        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_cnt_w-1:0] r_deb_cnt;
        logic [c_cnt_w-1:0] w_deb_cnt_nxt;
        logic [c_cnt_w-1:0] r_rep_cnt;
        logic [c_cnt_w-1:0] w_rep_cnt_nxt;
        logic               r_rep_phase;      // 0: waiting initial delay, 1: periodic
        logic               w_rep_phase_nxt;
        logic               r_pulse;
        logic               w_pulse_nxt;
        logic               w_in;

        assign w_in = w_pressed[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state     <= S_RELEASED;
                r_deb_cnt   <= '0;
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
                r_pulse     <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_deb_cnt   <= w_deb_cnt_nxt;
                r_rep_cnt   <= w_rep_cnt_nxt;
                r_rep_phase <= w_rep_phase_nxt;
                r_pulse     <= w_pulse_nxt;
            end
        end

        always_comb begin
            w_state_nxt     = r_state;
            w_deb_cnt_nxt   = r_deb_cnt;
            w_rep_cnt_nxt   = r_rep_cnt;
            w_rep_phase_nxt = r_rep_phase;
            w_pulse_nxt     = 1'b0;

            case (r_state)
                S_RELEASED: begin
                    if (w_in) begin
                        w_state_nxt   = S_PRESS_CHK;
                        w_deb_cnt_nxt = '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (!w_in) begin
                        w_state_nxt   = S_RELEASED;
                        w_deb_cnt_nxt = '0;
                    end else if (r_deb_cnt == c_db_last) begin
                        w_state_nxt     = S_PRESSED;
                        w_deb_cnt_nxt   = '0;
                        w_pulse_nxt     = 1'b1;
                        w_rep_cnt_nxt   = '0;
                        w_rep_phase_nxt = 1'b0;
                    end else begin
                        w_deb_cnt_nxt = sat_inc(r_deb_cnt);
                    end
                end
                S_PRESSED: begin
                    if (!w_in) begin
                        w_state_nxt   = S_RELEASE_CHK;
                        w_deb_cnt_nxt = '0;
                    end
                end
                S_RELEASE_CHK: begin
                    if (w_in) begin
                        // Bounce on release: resume hold, repeat timer untouched.
                        w_state_nxt   = S_PRESSED;
                        w_deb_cnt_nxt = '0;
                    end else if (r_deb_cnt == c_db_last) begin
                        w_state_nxt   = S_RELEASED;
                        w_deb_cnt_nxt = '0;
                    end else begin
                        w_deb_cnt_nxt = sat_inc(r_deb_cnt);
                    end
                end
                default: begin
                    w_state_nxt   = S_RELEASED;
                    w_deb_cnt_nxt = '0;
                end
            endcase

            // Auto-repeat runs through PRESSED and RELEASE_CHK, but never on
            // the edge that completes a release.
            if (c_rep_en && (r_state == S_PRESSED || r_state == S_RELEASE_CHK)
                && (w_state_nxt != S_RELEASED)) begin
                if (r_rep_cnt == (r_rep_phase ? c_rp_last : c_rd_last)) begin
                    w_pulse_nxt     = 1'b1;
                    w_rep_cnt_nxt   = '0;
                    w_rep_phase_nxt = 1'b1;
                end else begin
                    w_rep_cnt_nxt = sat_inc(r_rep_cnt);
                end
            end

            if (w_state_nxt == S_RELEASED) begin
                w_rep_cnt_nxt   = '0;
                w_rep_phase_nxt = 1'b0;
            end
        end

        assign btn_level[gi] = (r_state == S_PRESSED) || (r_state == S_RELEASE_CHK);
        assign btn_pulse[gi] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A run-length
//               reference model (level flips after DEBOUNCE+1 consecutive
//               disagreeing synchronized samples; repeats at fixed offsets
//               from the accepted press) is compared every cycle, plus
//               directed timing checks and a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int         DB   = 4;
    localparam int         RD   = 20;
    localparam int         RP   = 8;
    localparam logic [4:0] MASK = 5'b00110;
    localparam logic       AL   = 1'b1;
    localparam logic [4:0] IDLE = {5{AL}};

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK),
        .ACTIVE_LOW      (AL)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [4:0] m_ff1, m_ff2, m_level, m_pulse;
    int         m_run [5];
    int         m_press_t [5];
    int         cyc;

    // Observation logs
    int         plog [5][$];
    int         nfall [5];
    int         fall_t [5];
    int         hi_cnt [5];
    int         both_cnt;
    logic [4:0] prev_level;

    function automatic int pget(input int ch, input int idx);
        if (idx < plog[ch].size()) return plog[ch][idx];
        return -1000;
    endfunction

    task automatic clear_logs();
        for (int ch = 0; ch < 5; ch++) begin
            plog[ch].delete();
            nfall[ch]  = 0;
            fall_t[ch] = -1000;
            hi_cnt[ch] = 0;
        end
        both_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            m_ff1   = IDLE;
            m_ff2   = IDLE;
            m_level = '0;
            m_pulse = '0;
            for (int ch = 0; ch < 5; ch++) m_run[ch] = 0;
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                logic s;
                logic was;
                int   k;
                s   = AL ? ~m_ff2[ch] : m_ff2[ch];
                was = m_level[ch];
                m_pulse[ch] = 1'b0;
                if (s != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DB + 1) begin
                        m_level[ch] = ~m_level[ch];
                        m_run[ch]   = 0;
                        if (m_level[ch]) begin
                            m_press_t[ch] = cyc;
                            m_pulse[ch]   = 1'b1;
                        end
                    end
                end else begin
                    m_run[ch] = 0;
                end
                if (was && m_level[ch] && MASK[ch]) begin
                    k = cyc - m_press_t[ch];
                    if (k == RD || (k > RD && (k - RD) % RP == 0)) m_pulse[ch] = 1'b1;
                end
            end
            m_ff2 = m_ff1;
            m_ff1 = btn_raw;
        end
        check($sformatf("level@%0d", cyc), {27'd0, btn_level}, {27'd0, m_level});
        check($sformatf("pulse@%0d", cyc), {27'd0, btn_pulse}, {27'd0, m_pulse});
        for (int ch = 0; ch < 5; ch++) begin
            if (btn_pulse[ch]) plog[ch].push_back(cyc);
            if (prev_level[ch] && !btn_level[ch]) begin
                nfall[ch]++;
                fall_t[ch] = cyc;
            end
            if (btn_level[ch]) hi_cnt[ch]++;
        end
        if (btn_pulse == 5'b01001) both_cnt++;
        prev_level = btn_level;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int rep_exp [5] = '{0, 20, 28, 36, 44};
    int t0, tr, td;
    int hold [5];

    initial begin
        reset      = 1'b1;
        btn_raw    = IDLE;
        cyc        = 0;
        m_ff1      = IDLE;
        m_ff2      = IDLE;
        m_level    = '0;
        m_pulse    = '0;
        prev_level = '0;
        for (int ch = 0; ch < 5; ch++) begin
            m_run[ch]     = 0;
            m_press_t[ch] = 0;
        end
        clear_logs();

        // Reset state
        run(3);
        check("rst_level", {27'd0, btn_level}, 32'd0);
        check("rst_pulse", {27'd0, btn_pulse}, 32'd0);
        reset = 1'b0;
        run(5);

        // Clean press on channel 0 (no repeat)
        clear_logs();
        btn_raw[0] = 1'b0;
        t0 = cyc + 1;
        run(40);
        check("clean_npulse", plog[0].size(), 1);
        check("clean_latency", pget(0, 0) - t0, 6);
        check("clean_level", {31'd0, btn_level[0]}, 1);
        btn_raw[0] = 1'b1;
        run(12);

        // Bounce on channel 1 never accepted
        clear_logs();
        btn_raw[1] = 1'b0; run(2);
        btn_raw[1] = 1'b1; run(1);
        btn_raw[1] = 1'b0; run(3);
        btn_raw[1] = 1'b1; run(12);
        check("bounce_npulse", plog[1].size(), 0);
        check("bounce_level", hi_cnt[1], 0);

        // Auto-repeat on channel 2
        clear_logs();
        btn_raw[2] = 1'b0;
        t0 = cyc + 1;
        run(50);
        btn_raw[2] = 1'b1;
        tr = cyc + 1;
        run(12);
        check("rep_npulse", plog[2].size(), 5);
        check("rep_first", pget(2, 0) - t0, 6);
        for (int i = 1; i < 5; i++)
            check($sformatf("rep_off%0d", i), pget(2, i) - pget(2, 0), rep_exp[i]);
        check("rep_fall", fall_t[2] - tr, 6);

        // Release bounce on channel 1 keeps level and cadence
        clear_logs();
        btn_raw[1] = 1'b0; run(16);
        btn_raw[1] = 1'b1; run(2);
        btn_raw[1] = 1'b0; run(30);
        check("rbnc_nofall", nfall[1], 0);
        check("rbnc_level", {31'd0, btn_level[1]}, 1);
        btn_raw[1] = 1'b1;
        run(12);
        check("rbnc_npulse", plog[1].size(), 5);
        check("rbnc_off1", pget(1, 1) - pget(1, 0), 20);
        check("rbnc_off4", pget(1, 4) - pget(1, 0), 44);

        // Reset in the middle of a hold on channel 2
        clear_logs();
        btn_raw[2] = 1'b0;
        run(10);
        reset = 1'b1;
        run(1);
        check("rmid_level", {27'd0, btn_level}, 32'd0);
        check("rmid_pulse", {27'd0, btn_pulse}, 32'd0);
        reset = 1'b0;
        clear_logs();
        td = cyc + 1;
        run(40);
        check("rmid_latency", pget(2, 0) - td, 6);
        check("rmid_rep", pget(2, 1) - pget(2, 0), 20);
        btn_raw[2] = 1'b1;
        run(12);

        // Simultaneous press on channels 0 and 3
        clear_logs();
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        run(40);
        check("sim_both", both_cnt, 1);
        check("sim_n3", plog[3].size(), 1);
        check("sim_n0", plog[0].size(), 1);
        btn_raw = IDLE;
        run(12);

        // Randomized soak against the model
        for (int ch = 0; ch < 5; ch++) hold[ch] = $urandom_range(1, 40);
        for (int c = 0; c < 2000; c++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (hold[ch] == 0) begin
                    btn_raw[ch] = ~btn_raw[ch];
                    hold[ch] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6)
                                                           : $urandom_range(5, 70);
                end else begin
                    hold[ch]--;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        btn_raw = IDLE;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
